time_set_ctrl: RTL and testbench

//  Front-panel time-setting controller driving the clock core's load/addrs/data_in bus.

---
 rtl/time_set_pkg.sv | 32 +++
 rtl/time_set_ctrl_if.sv | 35 +++
 rtl/time_set_ctrl_btn_debounce.sv | 59 +++++
 rtl/time_set_ctrl.sv | 159 +++++++++++++++
 tb/tb_time_set_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/time_set_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : time_set_pkg
//  Purpose  : Shared types and constants for the front-panel time-setting
//             controller: FSM state encoding, clock-core field addresses and
//             per-field limits, plus the wrapping increment helper.
//  Revision : 1.0 - initial release
// ============================================================================
package time_set_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        EDIT_H = 2'd1,
        EDIT_M = 2'd2,
        EDIT_S = 2'd3
    } state_e;

    localparam logic [1:0] ADDR_SEC = 2'b00;
    localparam logic [1:0] ADDR_MIN = 2'b01;
    localparam logic [1:0] ADDR_HRS = 2'b10;

    localparam logic [5:0] MAX_HRS     = 6'd23;
    localparam logic [5:0] MAX_MIN_SEC = 6'd59;

    // Step a field value, returning to zero once the field maximum is passed.
    // ">=" also recovers from any out-of-range value.
    function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] max_val);
        return (value >= max_val) ? 6'd0 : value + 6'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/time_set_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : time_set_ctrl_if
//  Purpose  : Front-panel buttons plus the load/addrs/data_in bus toward the
//             clock core, and the display-override signals.
//  Signals  : btn_mode, btn_inc   raw active-high buttons (asynchronous)
//             load                one-cycle write strobe
//             addrs[1:0]          field select (00 sec, 01 min, 10 hrs)
//             data_in[5:0]        value written on load
//             editing             high while a field is being edited
//             edit_value[5:0]     value currently being edited
//  Modports : master - the controller (drives the bus, reads the buttons)
//             slave  - panel / clock-core side
//  Revision : 1.0 - initial release
// ============================================================================
interface time_set_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       load;
    logic [1:0] addrs;
    logic [5:0] data_in;
    logic       editing;
    logic [5:0] edit_value;

    modport master (
        input  btn_mode, btn_inc,
        output load, addrs, data_in, editing, edit_value
    );

    modport slave (
        output btn_mode, btn_inc,
        input  load, addrs, data_in, editing, edit_value
    );
endinterface
`default_nettype wire

// File: rtl/time_set_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : Two-flop synchronizer followed by a stable-level debouncer.
//             The debounced level only changes after the synchronized input
//             has differed from it for DEBOUNCE_CYCLES consecutive cycles.
//             o_press pulses for one cycle on each accepted 0->1 change.
//  Ports    : clk, reset (async, active-high), i_btn (raw button),
//             o_level (debounced level), o_press (one-cycle press pulse)
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_btn,
    output logic      o_level,
    output logic      o_press
);

    localparam int unsigned c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_level;
    logic               r_press;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_press <= 1'b0;
            // Any cycle where the input agrees with the accepted level
            // restarts the stability count, so glitches are discarded.
            if (r_sync[1] != r_level) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_level <= r_sync[1];
                    r_press <= r_sync[1];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : time_set_ctrl
//  Purpose  : Front-panel time-setting controller. Debounces MODE and INC,
//             steps RUN -> EDIT_H -> EDIT_M -> EDIT_S -> RUN on MODE presses,
//             edits the current field with INC (wrapping at 23 / 59) and
//             issues a one-cycle load of the edited value on each confirm.
//  Ports    : clk, reset (async, active-high), bus (time_set_ctrl_if.master)
//  Options  : AUTO_REPEAT_EN - holding INC auto-increments after REPEAT_DELAY
//             cycles, then every REPEAT_PERIOD cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
    input  wire logic        clk,
    input  wire logic        reset,
    time_set_ctrl_if.master  bus
);

    localparam logic [1:0] c_ST_RUN    = RUN;
    localparam logic [1:0] c_ST_EDIT_H = EDIT_H;
    localparam logic [1:0] c_ST_EDIT_M = EDIT_M;
    localparam logic [1:0] c_ST_EDIT_S = EDIT_S;

    logic       w_mode_press;
    logic       w_inc_press;
    logic       w_inc_evt;

    logic [1:0] r_state;
    logic [5:0] r_edit_value;
    logic       r_load;
    logic [1:0] r_addrs;
    logic [5:0] r_data_in;

    logic [1:0] w_field_addr;
    logic [5:0] w_field_max;
    logic [1:0] w_next_state;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (bus.btn_mode),
        .o_level (),
        .o_press (w_mode_press)
    );

`ifdef AUTO_REPEAT_EN
    logic w_inc_level;
`endif

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (bus.btn_inc),
`ifdef AUTO_REPEAT_EN
        .o_level (w_inc_level),
`else
        .o_level (),
`endif
        .o_press (w_inc_press)
    );

`ifdef AUTO_REPEAT_EN
    localparam int unsigned c_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned c_REP_W   = (c_REP_MAX > 1) ? $clog2(c_REP_MAX) : 1;
    localparam logic [c_REP_W-1:0] c_DELAY_LAST  = c_REP_W'(REPEAT_DELAY - 1);
    localparam logic [c_REP_W-1:0] c_PERIOD_LAST = c_REP_W'(REPEAT_PERIOD - 1);

    logic [c_REP_W-1:0] r_rep_cnt;
    logic               r_rep_active;   // initial delay has elapsed
    logic               w_rep_hold;
    logic               w_rep_due;

    // The press cycle itself counts as the first held cycle, hence the
    // counter restarting at 1 on a press.
    assign w_rep_hold = w_inc_level && (r_state != c_ST_RUN) && !w_mode_press;
    assign w_rep_due  = r_rep_active ? (r_rep_cnt == c_PERIOD_LAST) : (r_rep_cnt == c_DELAY_LAST);
    assign w_inc_evt  = w_inc_press || (w_rep_hold && w_rep_due);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rep_cnt    <= '0;
            r_rep_active <= 1'b0;
        end else if (!w_rep_hold) begin
            r_rep_cnt    <= '0;
            r_rep_active <= 1'b0;
        end else if (w_inc_press) begin
            r_rep_cnt    <= c_REP_W'(1);
            r_rep_active <= 1'b0;
        end else if (w_rep_due) begin
            r_rep_cnt    <= '0;
            r_rep_active <= 1'b1;
        end else begin
            r_rep_cnt    <= r_rep_cnt + 1'b1;
        end
    end
`else
    assign w_inc_evt = w_inc_press;
`endif

    always_comb begin
        w_field_addr = ADDR_HRS;
        w_field_max  = MAX_HRS;
        w_next_state = c_ST_EDIT_M;
        case (r_state)
            c_ST_EDIT_M: begin
                w_field_addr = ADDR_MIN;
                w_field_max  = MAX_MIN_SEC;
                w_next_state = c_ST_EDIT_S;
            end
            c_ST_EDIT_S: begin
                w_field_addr = ADDR_SEC;
                w_field_max  = MAX_MIN_SEC;
                w_next_state = c_ST_RUN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_RUN;
            r_edit_value <= 6'd0;
            r_load       <= 1'b0;
            r_addrs      <= ADDR_SEC;
            r_data_in    <= 6'd0;
        end else begin
            r_load <= 1'b0;
            if (r_state == c_ST_RUN) begin
                if (w_mode_press) begin
                    r_state      <= c_ST_EDIT_H;
                    r_edit_value <= 6'd0;
                end
            end else if (w_mode_press) begin
                // MODE has priority: a coincident INC is dropped.
                r_load       <= 1'b1;
                r_addrs      <= w_field_addr;
                r_data_in    <= r_edit_value;
                r_edit_value <= 6'd0;
                r_state      <= w_next_state;
            end else if (w_inc_evt) begin
                r_edit_value <= wrap_inc(r_edit_value, w_field_max);
            end
        end
    end

    assign bus.load       = r_load;
    assign bus.addrs      = r_addrs;
    assign bus.data_in    = r_data_in;
    assign bus.editing    = (r_state != c_ST_RUN);
    assign bus.edit_value = r_edit_value;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_time_set_ctrl
//  Purpose  : Directed self-checking bench for time_set_ctrl with short
//             debounce / repeat timings.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_time_set_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    time_set_ctrl_if bus_if();

    time_set_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Load log: every observed load pulse with its address/data.
    int         load_cnt = 0;
    int         dbl_load = 0;
    logic       prev_load = 1'b0;
    logic [7:0] log_ad [0:511];

    always @(negedge clk) begin
        if (bus_if.load === 1'b1) begin
            if (load_cnt < 512) log_ad[load_cnt] = {bus_if.addrs, bus_if.data_in};
            load_cnt = load_cnt + 1;
            if (prev_load === 1'b1) dbl_load = dbl_load + 1;
        end
        prev_load = bus_if.load;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_inc();
        bus_if.btn_inc = 1'b1;
        wait_cycles(10);
        bus_if.btn_inc = 1'b0;
        wait_cycles(10);
    endtask

    // Press MODE and report the cycle (1-based, after the raw edge) of the
    // first load seen, or 0 when none appears.
    task automatic press_mode(output int lat);
        lat = 0;
        bus_if.btn_mode = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus_if.load === 1'b1 && lat == 0) lat = i;
        end
        bus_if.btn_mode = 1'b0;
        wait_cycles(10);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cycles(2);
        checks += 5;
        if (bus_if.load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b want 0", bus_if.load); end
        if (bus_if.addrs !== 2'b00) begin errors++; $display("FAIL reset_addrs: got %b want 00", bus_if.addrs); end
        if (bus_if.data_in !== 6'd0) begin errors++; $display("FAIL reset_data_in: got %0d want 0", bus_if.data_in); end
        if (bus_if.editing !== 1'b0) begin errors++; $display("FAIL reset_editing: got %b want 0", bus_if.editing); end
        if (bus_if.edit_value !== 6'd0) begin errors++; $display("FAIL reset_edit_value: got %0d want 0", bus_if.edit_value); end
        reset = 1'b0;
        wait_cycles(2);
    endtask

    task automatic test_full_set();
        int lat;
        int n0;
        n0 = load_cnt;
        press_mode(lat);
        checks += 3;
        if (lat != 0) begin errors++; $display("FAIL run_mode_no_load: load at cycle %0d want none", lat); end
        if (bus_if.editing !== 1'b1) begin errors++; $display("FAIL enter_edit_h: editing %b want 1", bus_if.editing); end
        if (bus_if.edit_value !== 6'd0) begin errors++; $display("FAIL enter_edit_h_value: got %0d want 0", bus_if.edit_value); end
        repeat (13) press_inc();
        checks++;
        if (bus_if.edit_value !== 6'd13) begin errors++; $display("FAIL hours_13: got %0d want 13", bus_if.edit_value); end
        press_mode(lat);
        checks += 2;
        if (lat != 7) begin errors++; $display("FAIL mode_to_load_latency: load at cycle %0d want 7", lat); end
        if (bus_if.edit_value !== 6'd0) begin errors++; $display("FAIL min_start_value: got %0d want 0", bus_if.edit_value); end
        repeat (45) press_inc();
        press_mode(lat);
        repeat (7) press_inc();
        press_mode(lat);
        checks += 8;
        if (load_cnt - n0 != 3) begin errors++; $display("FAIL full_set_load_count: got %0d want 3", load_cnt - n0); end
        if (log_ad[n0] !== {2'b10, 6'd13}) begin errors++; $display("FAIL load_hours: got %h want %h", log_ad[n0], {2'b10, 6'd13}); end
        if (log_ad[n0+1] !== {2'b01, 6'd45}) begin errors++; $display("FAIL load_minutes: got %h want %h", log_ad[n0+1], {2'b01, 6'd45}); end
        if (log_ad[n0+2] !== {2'b00, 6'd7}) begin errors++; $display("FAIL load_seconds: got %h want %h", log_ad[n0+2], {2'b00, 6'd7}); end
        if (bus_if.editing !== 1'b0) begin errors++; $display("FAIL full_set_editing_end: got %b want 0", bus_if.editing); end
        if (bus_if.addrs !== 2'b00) begin errors++; $display("FAIL addrs_hold: got %b want 00", bus_if.addrs); end
        if (bus_if.data_in !== 6'd7) begin errors++; $display("FAIL data_in_hold: got %0d want 7", bus_if.data_in); end
        if (dbl_load != 0) begin errors++; $display("FAIL load_single_cycle: %0d doubled loads want 0", dbl_load); end
    endtask

    task automatic test_wrap();
        int lat;
        do_reset();
        press_mode(lat);
        repeat (23) press_inc();
        checks++;
        if (bus_if.edit_value !== 6'd23) begin errors++; $display("FAIL hours_max: got %0d want 23", bus_if.edit_value); end
        press_inc();
        checks++;
        if (bus_if.edit_value !== 6'd0) begin errors++; $display("FAIL hours_wrap: got %0d want 0", bus_if.edit_value); end
        press_mode(lat);
        repeat (59) press_inc();
        checks++;
        if (bus_if.edit_value !== 6'd59) begin errors++; $display("FAIL minutes_max: got %0d want 59", bus_if.edit_value); end
        press_inc();
        checks++;
        if (bus_if.edit_value !== 6'd0) begin errors++; $display("FAIL minutes_wrap: got %0d want 0", bus_if.edit_value); end
    endtask

    task automatic test_bounce();
        int lat;
        do_reset();
        press_mode(lat);
        bus_if.btn_inc = 1'b1;
        wait_cycles(3);
        bus_if.btn_inc = 1'b0;
        wait_cycles(12);
        checks++;
        if (bus_if.edit_value !== 6'd0) begin errors++; $display("FAIL glitch_rejected: got %0d want 0", bus_if.edit_value); end
        press_inc();
        checks++;
        if (bus_if.edit_value !== 6'd1) begin errors++; $display("FAIL clean_press: got %0d want 1", bus_if.edit_value); end
    endtask

    task automatic test_simultaneous();
        int lat;
        int n0;
        do_reset();
        press_mode(lat);
        press_mode(lat);
        repeat (5) press_inc();
        n0 = load_cnt;
        lat = 0;
        bus_if.btn_mode = 1'b1;
        bus_if.btn_inc  = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus_if.load === 1'b1 && lat == 0) lat = i;
        end
        bus_if.btn_mode = 1'b0;
        bus_if.btn_inc  = 1'b0;
        wait_cycles(10);
        checks += 4;
        if (lat != 7) begin errors++; $display("FAIL simul_load_latency: load at cycle %0d want 7", lat); end
        if (log_ad[n0] !== {2'b01, 6'd5}) begin errors++; $display("FAIL simul_load_value: got %h want %h", log_ad[n0], {2'b01, 6'd5}); end
        if (bus_if.edit_value !== 6'd0) begin errors++; $display("FAIL simul_inc_discarded: got %0d want 0", bus_if.edit_value); end
        if (bus_if.editing !== 1'b1) begin errors++; $display("FAIL simul_in_edit_s: editing %b want 1", bus_if.editing); end
        n0 = load_cnt;
        press_mode(lat);
        checks += 2;
        if (log_ad[n0] !== {2'b00, 6'd0}) begin errors++; $display("FAIL seconds_after_simul: got %h want %h", log_ad[n0], {2'b00, 6'd0}); end
        if (bus_if.editing !== 1'b0) begin errors++; $display("FAIL back_to_run: editing %b want 0", bus_if.editing); end
    endtask

    task automatic test_reset_mid_edit();
        int lat;
        int n0;
        do_reset();
        press_mode(lat);
        repeat (2) press_inc();
        press_mode(lat);
        repeat (3) press_inc();
        checks += 2;
        if (bus_if.edit_value !== 6'd3) begin errors++; $display("FAIL pre_reset_value: got %0d want 3", bus_if.edit_value); end
        if (bus_if.addrs !== 2'b10 || bus_if.data_in !== 6'd2) begin
            errors++; $display("FAIL pre_reset_bus: got %b/%0d want 10/2", bus_if.addrs, bus_if.data_in);
        end
        n0 = load_cnt;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks += 5;
        if (bus_if.editing !== 1'b0) begin errors++; $display("FAIL async_editing: got %b want 0", bus_if.editing); end
        if (bus_if.edit_value !== 6'd0) begin errors++; $display("FAIL async_edit_value: got %0d want 0", bus_if.edit_value); end
        if (bus_if.load !== 1'b0) begin errors++; $display("FAIL async_load: got %b want 0", bus_if.load); end
        if (bus_if.addrs !== 2'b00) begin errors++; $display("FAIL async_addrs: got %b want 00", bus_if.addrs); end
        if (bus_if.data_in !== 6'd0) begin errors++; $display("FAIL async_data_in: got %0d want 0", bus_if.data_in); end
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(10);
        checks += 2;
        if (load_cnt != n0) begin errors++; $display("FAIL reset_no_load: %0d loads want 0", load_cnt - n0); end
        if (bus_if.editing !== 1'b0) begin errors++; $display("FAIL reset_stays_run: editing %b want 0", bus_if.editing); end
    endtask

    task automatic test_auto_repeat();
        int lat;
        int exp_val;
`ifdef AUTO_REPEAT_EN
        exp_val = 6;
`else
        exp_val = 1;
`endif
        do_reset();
        press_mode(lat);
        press_mode(lat);
        press_mode(lat);
        bus_if.btn_inc = 1'b1;
        wait_cycles(40);
        bus_if.btn_inc = 1'b0;
        wait_cycles(15);
        checks += 2;
        if (bus_if.edit_value !== 6'(exp_val)) begin errors++; $display("FAIL hold_increments: got %0d want %0d", bus_if.edit_value, exp_val); end
        if (bus_if.editing !== 1'b1) begin errors++; $display("FAIL hold_still_edit_s: editing %b want 1", bus_if.editing); end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        bus_if.btn_mode = 1'b0;
        bus_if.btn_inc  = 1'b0;
        test_reset();
        test_full_set();
        test_wrap();
        test_bounce();
        test_simultaneous();
        test_reset_mid_edit();
        test_auto_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
